// File: rtl/counter_ultra_pkg.sv
// Shared types and default timing constants for the counter_ultra button path.
// Cycle thresholds come from the *_MS constants via ms_to_cycles at instantiation.
`timescale 1ns/1ps
package counter_ultra_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HOLD = 2'd2
  } btn_state_t;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned LONG_MS   = 500;
  localparam int unsigned REPEAT_MS = 100;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat pulses plus a merged step strobe.
// Latency: 1 cycle from the sampling edge; no backpressure, pulses are fire-and-forget.
`timescale 1ns/1ps
module button_event_decoder
  import counter_ultra_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk_core,
  input  logic rst_n,
  input  logic button_i,
  input  logic enable_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic step_o,
  output logic held_o
);

  localparam int unsigned MAX_CYCLES =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;

  if (LONG_CYCLES < 2) begin : g_bad_long
    $fatal(1, "button_event_decoder: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $fatal(1, "button_event_decoder: REPEAT_CYCLES must be >= 1");
  end
  if ((CNT_W < 1) || ((CNT_W < 64) && ((64'd1 << CNT_W) <= 64'(MAX_CYCLES)))) begin : g_bad_cnt_w
    $fatal(1, "button_event_decoder: CNT_W too narrow for the hold thresholds");
  end

  localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             btn_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             step_q, step_d;
  logic             held_q, held_d;
  logic             rise;

  assign rise = button_i & ~btn_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    // Disable aborts silently: no release for a press we stop tracking.
    if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_d = '0;
          if (rise) begin
            state_d = PRESSED;
            timer_d = ONE;
            press_d = 1'b1;
          end
        end
        PRESSED: begin
          if (!button_i) begin
            state_d   = IDLE;
            timer_d   = '0;
            release_d = 1'b1;
          end else if (timer_q == LONG_T) begin
            state_d = LONG_HOLD;
            timer_d = ONE;
            long_d  = 1'b1;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        LONG_HOLD: begin
          if (!button_i) begin
            state_d   = IDLE;
            timer_d   = '0;
            release_d = 1'b1;
          end else if (timer_q == REPEAT_T) begin
            timer_d  = ONE;
            repeat_d = 1'b1;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    step_d = press_d | long_d | repeat_d;
    held_d = (state_d != IDLE);
  end

  // btn_q resets high so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      btn_q     <= button_i;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign step_o    = step_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: expectations queued at drive time, compared after each edge.
`timescale 1ns/1ps
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int REP  = 3;

  logic clk_core;
  logic rst_n;
  logic button_i;
  logic enable_i;
  logic press_o, release_o, long_o, repeat_o, step_o, held_o;

  button_event_decoder #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .CNT_W        (4)
  ) dut (
    .clk_core (clk_core),
    .rst_n    (rst_n),
    .button_i (button_i),
    .enable_i (enable_i),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .repeat_o (repeat_o),
    .step_o   (step_o),
    .held_o   (held_o)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {press, release, long, repeat, step, held}
  function automatic logic [5:0] obs();
    return {press_o, release_o, long_o, repeat_o, step_o, held_o};
  endfunction

  function automatic logic [5:0] ev(input bit p, input bit r, input bit l,
                                    input bit rp, input bit h);
    return {p, r, l, rp, (p | l | rp), h};
  endfunction

  // Expected outputs i cycles after the press pulse for a hold lasting h cycles.
  function automatic logic [5:0] hold_exp(input int i, input int h);
    bit p, r, l, rp;
    p  = (i == 0);
    r  = (i == h);
    l  = (i == LONG) && (i < h);
    rp = (i < h) && (i > LONG) && (((i - LONG) % REP) == 0);
    return ev(p, r, l, rp, (i < h));
  endfunction

  task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic step(input logic btn, input logic en, input logic [5:0] e, input string tag);
    exp_t t;
    @(negedge clk_core);
    button_i = btn;
    enable_i = en;
    t.tag = tag;
    t.vec = e;
    exp_q.push_back(t);
  endtask

  task automatic press_hold(input string tag, input int h);
    for (int i = 0; i <= h; i++) step((i < h), 1'b1, hold_exp(i, h), tag);
    repeat (2) step(1'b0, 1'b1, 6'b0, {tag, "_idle"});
  endtask

  initial begin
    forever begin
      @(posedge clk_core);
      #1;
      if (exp_q.size() > 0) begin
        exp_t t;
        t = exp_q.pop_front();
        check(t.tag, obs(), t.vec);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    button_i = 1'b0;
    enable_i = 1'b1;
    #12;
    check("reset_outs", obs(), 6'b0);
    @(negedge clk_core);
    rst_n = 1'b1;

    repeat (2) step(1'b0, 1'b1, 6'b0, "pre_idle");
    press_hold("tap", 4);
    press_hold("long", 20);
    press_hold("thresh", 8);

    // Button held across reset.
    @(negedge clk_core);
    button_i = 1'b1;
    rst_n    = 1'b0;
    #2;
    check("thr_in_reset", obs(), 6'b0);
    @(negedge clk_core);
    rst_n = 1'b1;
    repeat (12) step(1'b1, 1'b1, 6'b0, "thr_hold");
    repeat (2) step(1'b0, 1'b1, 6'b0, "thr_rel");
    press_hold("thr_tap", 4);

    // Enable dropped during long-hold.
    for (int i = 0; i <= 9; i++) step(1'b1, 1'b1, hold_exp(i, 100), "en_hold");
    repeat (3) step(1'b1, 1'b0, 6'b0, "en_off");
    repeat (4) step(1'b1, 1'b1, 6'b0, "en_back");
    repeat (2) step(1'b0, 1'b1, 6'b0, "en_rel");
    press_hold("en_tap", 4);

    // Asynchronous reset pulse between edges while in long-hold.
    for (int i = 0; i <= 12; i++) step(1'b1, 1'b1, hold_exp(i, 100), "ar_hold");
    @(posedge clk_core);
    #2 rst_n = 1'b0;
    #1 check("ar_async", obs(), 6'b0);
    #1 rst_n = 1'b1;
    repeat (5) step(1'b1, 1'b1, 6'b0, "ar_idle");
    repeat (2) step(1'b0, 1'b1, 6'b0, "ar_rel");
    press_hold("ar_tap", 4);

    repeat (3) @(posedge clk_core);
    #2;
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
